// File: rtl/map_mem_dp_if.sv
// rtl/map_mem_dp_if.sv - s1 (read/write) and s2 (read-only) bus bundle for map_mem_dp
interface map_mem_dp_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  // s1: read/write port with byte enables and wait-request
  logic [ADDR_W-1:0]   s1_address;
  logic                s1_chipselect;
  logic                s1_read;
  logic                s1_write;
  logic [DATA_W/8-1:0] s1_byteenable;
  logic [DATA_W-1:0]   s1_writedata;
  logic [DATA_W-1:0]   s1_readdata;
  logic                s1_readdatavalid;
  logic                s1_waitrequest;

  // s2: read-only port for the display/game logic
  logic [ADDR_W-1:0]   s2_address;
  logic                s2_read;
  logic [DATA_W-1:0]   s2_readdata;
  logic                s2_readdatavalid;

  modport master (
    output s1_address, s1_chipselect, s1_read, s1_write, s1_byteenable, s1_writedata,
    input  s1_readdata, s1_readdatavalid, s1_waitrequest,
    output s2_address, s2_read,
    input  s2_readdata, s2_readdatavalid
  );

  modport slave (
    input  s1_address, s1_chipselect, s1_read, s1_write, s1_byteenable, s1_writedata,
    output s1_readdata, s1_readdatavalid, s1_waitrequest,
    input  s2_address, s2_read,
    output s2_readdata, s2_readdatavalid
  );
endinterface

// File: rtl/map_mem_dp.sv
// rtl/map_mem_dp.sv - dual-port map RAM with byte-enable writes and built-in clear sequencer
module map_mem_dp #(
  parameter int                DATA_W         = 8,
  parameter int                ADDR_W         = 4,
  parameter logic [DATA_W-1:0] CLEAR_VAL      = '0,
  parameter bit                CLEAR_ON_RESET = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         reset_req,
  input  logic         clear_start,
  output logic         busy,
  map_mem_dp_if.slave  bus
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int NB    = DATA_W / 8;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  // Pending post-reset clear: lets the first write land on the very first
  // edge after reset deasserts while the FSM itself still resets to IDLE.
  logic              clr_arm_q, clr_arm_d;

  logic [DATA_W-1:0] s1_rdata_q, s1_rdata_d;
  logic              s1_rvalid_q, s1_rvalid_d;
  logic [DATA_W-1:0] s2_rdata_q, s2_rdata_d;
  logic              s2_rvalid_q, s2_rvalid_d;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              clearing;
  logic              s1_wait;
  logic              s1_acc;
  logic              s1_wr;
  logic              s1_rd;
  logic              s2_rd;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [NB-1:0]     mem_be;

  assign clearing = ~reset & ((state_q == CLEAR) | clr_arm_q);
  assign busy     = clearing;
  assign s1_wait  = clearing | reset_req | reset;

  // A combined read+write performs only the write.
  assign s1_acc = bus.s1_chipselect & (bus.s1_read | bus.s1_write) & ~s1_wait;
  assign s1_wr  = s1_acc & bus.s1_write;
  assign s1_rd  = s1_acc & bus.s1_read & ~bus.s1_write;
  assign s2_rd  = bus.s2_read & ~reset_req & ~reset;

  // Clear and s1 writes never overlap because s1 is stalled while clearing.
  assign mem_we    = clearing | s1_wr;
  assign mem_waddr = clearing ? clr_addr_q : bus.s1_address;
  assign mem_wdata = clearing ? CLEAR_VAL : bus.s1_writedata;
  assign mem_be    = clearing ? {NB{1'b1}} : bus.s1_byteenable;

  // Clear sequencer next state: one address per cycle, stop after DEPTH-1.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    clr_arm_d  = clr_arm_q;
    case (state_q)
      IDLE: begin
        if (clr_arm_q) begin
          state_d    = CLEAR;
          clr_addr_d = clr_addr_q + 1'b1;
          clr_arm_d  = 1'b0;
        end else if (clear_start) begin
          state_d    = CLEAR;
          clr_addr_d = '0;
        end
      end
      CLEAR: begin
        clr_addr_d = clr_addr_q + 1'b1;
        if (clr_addr_q == {ADDR_W{1'b1}}) begin
          state_d    = IDLE;
          clr_addr_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Read pipelines: sample the array on the accept edge, hold data otherwise.
  always_comb begin
    s1_rvalid_d = s1_rd;
    s1_rdata_d  = s1_rd ? mem[bus.s1_address] : s1_rdata_q;
    s2_rvalid_d = s2_rd;
    s2_rdata_d  = s2_rd ? mem[bus.s2_address] : s2_rdata_q;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      clr_addr_q  <= '0;
      clr_arm_q   <= CLEAR_ON_RESET;
      s1_rdata_q  <= '0;
      s1_rvalid_q <= 1'b0;
      s2_rdata_q  <= '0;
      s2_rvalid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_addr_q  <= clr_addr_d;
      clr_arm_q   <= clr_arm_d;
      s1_rdata_q  <= s1_rdata_d;
      s1_rvalid_q <= s1_rvalid_d;
      s2_rdata_q  <= s2_rdata_d;
      s2_rvalid_q <= s2_rvalid_d;
    end
  end

  // Storage array: byte-masked write; reads in the same edge see old data.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < NB; b++) begin
        if (mem_be[b]) begin
          mem[mem_waddr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
      end
    end
  end

  // Outputs are forced quiet while reset is held, including before its first edge.
  assign bus.s1_waitrequest   = s1_wait;
  assign bus.s1_readdata      = reset ? '0 : s1_rdata_q;
  assign bus.s1_readdatavalid = ~reset & s1_rvalid_q;
  assign bus.s2_readdata      = reset ? '0 : s2_rdata_q;
  assign bus.s2_readdatavalid = ~reset & s2_rvalid_q;

endmodule

// File: tb/tb_map_mem_dp.sv
// tb/tb_map_mem_dp.sv - directed self-checking bench for map_mem_dp
module tb_map_mem_dp;

  logic clk;
  logic reset;
  logic reset_req;
  logic clear_start8;
  logic clear_start32;
  logic busy8;
  logic busy32;

  int n_assert = 0;
  int n_fail   = 0;

  map_mem_dp_if #(.DATA_W(8),  .ADDR_W(4)) bus8 ();
  map_mem_dp_if #(.DATA_W(32), .ADDR_W(4)) bus32 ();

  map_mem_dp #(.DATA_W(8), .ADDR_W(4), .CLEAR_VAL(8'h00), .CLEAR_ON_RESET(1'b1)) dut8 (
    .clk         (clk),
    .reset       (reset),
    .reset_req   (reset_req),
    .clear_start (clear_start8),
    .busy        (busy8),
    .bus         (bus8)
  );

  map_mem_dp #(.DATA_W(32), .ADDR_W(4), .CLEAR_VAL(32'h0), .CLEAR_ON_RESET(1'b1)) dut32 (
    .clk         (clk),
    .reset       (reset),
    .reset_req   (reset_req),
    .clear_start (clear_start32),
    .busy        (busy32),
    .bus         (bus32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  cnt_b;
    int  cnt_w;
    int  cnt_b32;
    int  k;
    int  nval;
    bit  rr;
    bit  acc;

    reset         = 1'b1;
    reset_req     = 1'b0;
    clear_start8  = 1'b0;
    clear_start32 = 1'b0;
    bus8.s1_address = '0;  bus8.s1_chipselect = 1'b0; bus8.s1_read = 1'b0; bus8.s1_write = 1'b0;
    bus8.s1_byteenable = '0; bus8.s1_writedata = '0; bus8.s2_address = '0; bus8.s2_read = 1'b0;
    bus32.s1_address = '0; bus32.s1_chipselect = 1'b0; bus32.s1_read = 1'b0; bus32.s1_write = 1'b0;
    bus32.s1_byteenable = '0; bus32.s1_writedata = '0; bus32.s2_address = '0; bus32.s2_read = 1'b0;

    // Outputs while reset is held
    #1;
    chk("rst_busy", 32'(busy8), 0);
    chk("rst_wait", 32'(bus8.s1_waitrequest), 1);
    chk("rst_s1_valid", 32'(bus8.s1_readdatavalid), 0);
    chk("rst_s2_data", 32'(bus8.s2_readdata), 0);
    cyc();
    cyc();

    // Post-reset clear: busy and waitrequest high for exactly 16 cycles
    reset = 1'b0;
    cnt_b = 0; cnt_w = 0; cnt_b32 = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (busy8) cnt_b++;
      if (bus8.s1_waitrequest) cnt_w++;
      if (busy32) cnt_b32++;
      cyc();
    end
    chk("reset_clear_busy", 32'(cnt_b), 16);
    chk("reset_clear_wait", 32'(cnt_w), 16);
    chk("reset_clear_busy32", 32'(cnt_b32), 16);

    // s2 reads of every address return the fill value, back to back
    for (int a = 0; a < 16; a++) begin
      bus8.s2_read = 1'b1;
      bus8.s2_address = 4'(a);
      cyc();
      chk("s2_clear_valid", 32'(bus8.s2_readdatavalid), 1);
      chk("s2_clear_data", 32'(bus8.s2_readdata), 0);
    end
    bus8.s2_read = 1'b0;
    cyc();
    chk("s2_valid_idle", 32'(bus8.s2_readdatavalid), 0);

    // s1 write 0xA5 to address 3, read it back the next cycle
    bus8.s1_chipselect = 1'b1; bus8.s1_write = 1'b1; bus8.s1_byteenable = 1'b1;
    bus8.s1_address = 4'd3; bus8.s1_writedata = 8'hA5;
    #1;
    chk("s1_wait_idle", 32'(bus8.s1_waitrequest), 0);
    cyc();
    bus8.s1_write = 1'b0; bus8.s1_read = 1'b1;
    chk("s1_valid_after_write", 32'(bus8.s1_readdatavalid), 0);
    cyc();
    bus8.s1_chipselect = 1'b0; bus8.s1_read = 1'b0;
    chk("s1_rd_valid", 32'(bus8.s1_readdatavalid), 1);
    chk("s1_rd_data", 32'(bus8.s1_readdata), 32'hA5);
    cyc();
    chk("s1_valid_drop", 32'(bus8.s1_readdatavalid), 0);
    chk("s1_data_hold", 32'(bus8.s1_readdata), 32'hA5);

    // 32-bit byte-enable merge
    bus32.s1_chipselect = 1'b1; bus32.s1_write = 1'b1; bus32.s1_address = 4'd2;
    bus32.s1_byteenable = 4'b1111; bus32.s1_writedata = 32'h11223344;
    cyc();
    bus32.s1_byteenable = 4'b0101; bus32.s1_writedata = 32'hFFFFFFFF;
    cyc();
    bus32.s1_write = 1'b0; bus32.s1_read = 1'b1;
    cyc();
    bus32.s1_chipselect = 1'b0; bus32.s1_read = 1'b0;
    chk("be32_valid", 32'(bus32.s1_readdatavalid), 1);
    chk("be32_data", bus32.s1_readdata, 32'h11FF33FF);

    // Same-address s1 write / s2 read collision returns old data
    bus8.s1_chipselect = 1'b1; bus8.s1_write = 1'b1; bus8.s1_address = 4'd5;
    bus8.s1_writedata = 8'h7E;
    bus8.s2_read = 1'b1; bus8.s2_address = 4'd5;
    cyc();
    bus8.s1_chipselect = 1'b0; bus8.s1_write = 1'b0;
    chk("coll_s2_valid", 32'(bus8.s2_readdatavalid), 1);
    chk("coll_s2_old", 32'(bus8.s2_readdata), 0);
    cyc();
    bus8.s2_read = 1'b0;
    chk("coll_s2_new", 32'(bus8.s2_readdata), 32'h7E);

    // Read and write together: write wins, no read strobe
    bus8.s1_chipselect = 1'b1; bus8.s1_read = 1'b1; bus8.s1_write = 1'b1;
    bus8.s1_address = 4'd6; bus8.s1_writedata = 8'h3C;
    cyc();
    bus8.s1_write = 1'b0;
    chk("rw_no_valid", 32'(bus8.s1_readdatavalid), 0);
    cyc();
    bus8.s1_chipselect = 1'b0; bus8.s1_read = 1'b0;
    chk("rw_read_back", 32'(bus8.s1_readdata), 32'h3C);

    // clear_start: s1 read of address 3 held off 16 cycles; a second pulse is ignored
    clear_start8 = 1'b1;
    cyc();
    clear_start8 = 1'b0;
    bus8.s1_chipselect = 1'b1; bus8.s1_read = 1'b1; bus8.s1_address = 4'd3;
    cnt_b = 0; cnt_w = 0;
    for (int i = 0; i < 20; i++) begin
      clear_start8 = (i == 4);
      #1;
      if (busy8) cnt_b++;
      if (bus8.s1_waitrequest) cnt_w++;
      cyc();
    end
    clear_start8 = 1'b0;
    bus8.s1_chipselect = 1'b0; bus8.s1_read = 1'b0;
    chk("cmd_clear_busy", 32'(cnt_b), 16);
    chk("cmd_clear_wait", 32'(cnt_w), 16);
    chk("cmd_clear_rd_valid", 32'(bus8.s1_readdatavalid), 1);
    chk("cmd_clear_rd_data", 32'(bus8.s1_readdata), 0);
    bus8.s2_read = 1'b1; bus8.s2_address = 4'd6;
    cyc();
    bus8.s2_read = 1'b0;
    chk("cmd_clear_s2_data", 32'(bus8.s2_readdata), 0);

    // Reset in the middle of a clear restarts a full clear
    bus8.s1_chipselect = 1'b1; bus8.s1_write = 1'b1; bus8.s1_address = 4'd15;
    bus8.s1_writedata = 8'h5A;
    cyc();
    bus8.s1_chipselect = 1'b0; bus8.s1_write = 1'b0;
    clear_start8 = 1'b1;
    cyc();
    clear_start8 = 1'b0;
    repeat (8) cyc();
    reset = 1'b1;
    #1;
    chk("midclr_rst_busy", 32'(busy8), 0);
    chk("midclr_rst_wait", 32'(bus8.s1_waitrequest), 1);
    cyc();
    cyc();
    reset = 1'b0;
    cnt_b = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (busy8) cnt_b++;
      cyc();
    end
    chk("midclr_rerun_busy", 32'(cnt_b), 16);
    bus8.s2_read = 1'b1; bus8.s2_address = 4'd15;
    cyc();
    bus8.s2_read = 1'b0;
    chk("midclr_addr15", 32'(bus8.s2_readdata), 0);

    // Fill addresses 1..4 with 0x11..0x14 back to back
    for (int a = 1; a <= 4; a++) begin
      bus8.s1_chipselect = 1'b1; bus8.s1_write = 1'b1;
      bus8.s1_address = 4'(a); bus8.s1_writedata = 8'(8'h10 + a);
      cyc();
    end
    bus8.s1_chipselect = 1'b0; bus8.s1_write = 1'b0;

    // reset_req for 3 cycles during s1 / s2 read traffic
    k = 0; nval = 0;
    for (int c = 0; c < 12; c++) begin
      rr = (c >= 1 && c <= 3);
      reset_req = rr;
      if (k < 4) begin
        bus8.s1_chipselect = 1'b1; bus8.s1_read = 1'b1; bus8.s1_address = 4'(k + 1);
      end else begin
        bus8.s1_chipselect = 1'b0; bus8.s1_read = 1'b0;
      end
      bus8.s2_read = 1'b1; bus8.s2_address = 4'd2;
      #1;
      chk("rr_s1_wait", 32'(bus8.s1_waitrequest), 32'(rr));
      acc = (k < 4) && !rr;
      cyc();
      if (bus8.s1_readdatavalid) nval++;
      chk("rr_s1_valid", 32'(bus8.s1_readdatavalid), 32'(acc));
      if (acc) begin
        chk("rr_s1_data", 32'(bus8.s1_readdata), 32'(8'h11 + k));
        k++;
      end
      chk("rr_s2_valid", 32'(bus8.s2_readdatavalid), 32'(!rr));
      if (!rr) chk("rr_s2_data", 32'(bus8.s2_readdata), 32'h12);
    end
    reset_req = 1'b0;
    bus8.s1_chipselect = 1'b0; bus8.s1_read = 1'b0; bus8.s2_read = 1'b0;
    chk("rr_total_reads", 32'(nval), 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
